// File: rtl/display_scan.sv
// ---------------------------------------------------------------------------
// display_scan
//   Time-multiplexes a 16-bit display word across four common-anode digits
//   feeding the Neander hex 7-segment decoder. New words are double-buffered
//   and only committed when scanning wraps back to digit 0, so a frame never
//   shows a mix of old and new nibbles.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   load      in   single-cycle strobe, captures value into the pending buffer
//   value     in   [15:0] word to display (digit 3 = value[15:12])
//   blank_lz  in   1 = suppress leading-zero digits (combinational effect)
//   sb3..sb0  out  nibble of the digit currently being scanned
//   an        out  [3:0] active-low digit enables
//   frame     out  one-cycle pulse on the cycle a commit boundary occurs
// ---------------------------------------------------------------------------
module display_scan #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic        sb3,
  output logic        sb2,
  output logic        sb1,
  output logic        sb0,
  output logic [3:0]  an,
  output logic        frame
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(PRESCALE - 1);

  // Registered state
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shown_q, shown_d;
  logic [15:0]      pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             frame_q, frame_d;

  // Scan timing strobes
  logic tick_c;
  logic boundary_c;

  // Display decode
  logic [3:0] nibble_c;
  logic       lz3_c, lz2_c, lz1_c;
  logic       digit_blank_c;
  logic [3:0] an_c;

  // Slot timing: a commit boundary is the last cycle of digit 3
  always_comb begin
    tick_c     = (presc_q == PRESC_MAX);
    boundary_c = tick_c && (idx_q == 2'd3);
  end

  // Next-state logic
  always_comb begin
    presc_d    = presc_q;
    idx_d      = idx_q;
    shown_d    = shown_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    frame_d    = 1'b0;

    if (tick_c) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end else begin
      presc_d = presc_q + CNT_W'(1);
    end

    if (boundary_c) begin
      frame_d = 1'b1;
      if (pend_q) begin
        shown_d = pend_val_q;
        pend_d  = 1'b0;
      end
    end

    // A load on the boundary cycle is applied after the commit above, so it
    // re-arms the pending buffer for the following frame.
    if (load) begin
      pend_val_d = value;
      pend_d     = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      idx_q      <= 2'd0;
      shown_q    <= 16'h0000;
      pend_val_q <= 16'h0000;
      pend_q     <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      shown_q    <= shown_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      frame_q    <= frame_d;
    end
  end

  // Nibble of the digit being scanned
  always_comb begin
    nibble_c = shown_q[3:0];
    case (idx_q)
      2'd0: nibble_c = shown_q[3:0];
      2'd1: nibble_c = shown_q[7:4];
      2'd2: nibble_c = shown_q[11:8];
      2'd3: nibble_c = shown_q[15:12];
      default: nibble_c = shown_q[3:0];
    endcase
  end

  // Leading-zero chain: digit i is a leading zero iff nibbles i..3 are zero
  always_comb begin
    lz3_c = (shown_q[15:12] == 4'h0);
    lz2_c = lz3_c && (shown_q[11:8] == 4'h0);
    lz1_c = lz2_c && (shown_q[7:4] == 4'h0);
  end

  // Digit 0 is never blanked so an all-zero word still shows "0"
  always_comb begin
    digit_blank_c = 1'b0;
    case (idx_q)
      2'd1: digit_blank_c = blank_lz && lz1_c;
      2'd2: digit_blank_c = blank_lz && lz2_c;
      2'd3: digit_blank_c = blank_lz && lz3_c;
      default: digit_blank_c = 1'b0;
    endcase
  end

  // Active-low one-cold digit enable
  always_comb begin
    an_c = 4'b1110;
    case (idx_q)
      2'd0: an_c = 4'b1110;
      2'd1: an_c = 4'b1101;
      2'd2: an_c = 4'b1011;
      2'd3: an_c = 4'b0111;
      default: an_c = 4'b1110;
    endcase
    if (digit_blank_c) begin
      an_c = 4'b1111;
    end
  end

  assign {sb3, sb2, sb1, sb0} = nibble_c;
  assign an                   = an_c;
  assign frame                = frame_q;

endmodule
